// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Frame parser states plus the command and response byte values.
package uart_boot_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA,
        CHK,
        RESP,
        RUN
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_BOOT  = 8'h02;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h79;
    localparam logic [7:0] NAK_BYTE  = 8'h1F;

endpackage

// File: rtl/uart_boot_loader.sv
// Framed ICCM programmer: parses UART host frames into word writes,
// answers ACK/NAK and holds the core in reset until a valid BOOT frame.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         AddrW         = 12,
    parameter int         TimeoutCycles = 1_000_000,
    parameter logic [7:0] SyncByte      = SYNC_BYTE,
    parameter logic [7:0] AckByte       = ACK_BYTE,
    parameter logic [7:0] NakByte       = NAK_BYTE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_dv_i,
    input  logic [7:0]       rx_byte_i,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_byte_o,
    input  logic             tx_ready_i,
    output logic             core_hold_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles);

    state_e           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      word_q, word_d;
    logic             boot_q, boot_d;
    logic             ack_q, ack_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [7:0]       txb_q, txb_d;
    logic             err_q, err_d;
    logic             hold_q, hold_d;
    logic             in_frame;
    logic [7:0]       sum_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            boot_q  <= 1'b0;
            ack_q   <= 1'b0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            txb_q   <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            boot_q  <= boot_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            txb_q   <= txb_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        boot_d   = boot_q;
        ack_d    = ack_q;
        tmo_d    = '0;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        txb_d    = txb_q;
        err_d    = err_q;
        hold_d   = hold_q;
        sum_next = sum_q + rx_byte_i;
        in_frame = (state_q == CMD) || (state_q == ADDR_HI) ||
                   (state_q == ADDR_LO) || (state_q == LEN) ||
                   (state_q == DATA) || (state_q == CHK);

        // A byte arriving on the expiry cycle wins: timeout only when idle.
        if (in_frame && !rx_dv_i) begin
            if (tmo_q == TmoMax) begin
                state_d = RESP;
                txb_d   = NakByte;
                ack_d   = 1'b0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rx_dv_i && rx_byte_i == SyncByte) state_d = CMD;
            end
            CMD: begin
                if (rx_dv_i) begin
                    sum_d = rx_byte_i;
                    if (rx_byte_i == CMD_WRITE) begin
                        state_d = ADDR_HI;
                        boot_d  = 1'b0;
                    end else if (rx_byte_i == CMD_BOOT) begin
                        state_d = CHK;
                        boot_d  = 1'b1;
                    end else begin
                        state_d = RESP;
                        txb_d   = NakByte;
                        ack_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            ADDR_HI: begin
                if (rx_dv_i) begin
                    sum_d   = sum_next;
                    addr_d  = {rx_byte_i[AddrW-9:0], 8'h00};
                    state_d = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (rx_dv_i) begin
                    sum_d       = sum_next;
                    addr_d[7:0] = rx_byte_i;
                    state_d     = LEN;
                end
            end
            LEN: begin
                if (rx_dv_i) begin
                    sum_d   = sum_next;
                    cnt_d   = (rx_byte_i == 8'h00) ? 9'd256 : {1'b0, rx_byte_i};
                    idx_d   = 2'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rx_dv_i) begin
                    sum_d = sum_next;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = {rx_byte_i, word_q};
                        addr_d  = addr_q + AddrW'(1);
                        cnt_d   = cnt_q - 9'd1;
                        idx_d   = 2'd0;
                        if (cnt_q == 9'd1) state_d = CHK;
                    end else begin
                        word_d = {rx_byte_i, word_q[23:8]};
                        idx_d  = idx_q + 2'd1;
                    end
                end
            end
            CHK: begin
                if (rx_dv_i) begin
                    state_d = RESP;
                    if (sum_next == 8'h00) begin
                        txb_d = AckByte;
                        ack_d = 1'b1;
                        err_d = 1'b0;
                    end else begin
                        txb_d = NakByte;
                        ack_d = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (tx_ready_i) begin
                    if (ack_q && boot_q) begin
                        state_d = RUN;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                if (rx_dv_i && rx_byte_i == SyncByte) begin
                    state_d = CMD;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign we_o        = we_q;
    assign addr_o      = waddr_q;
    assign wdata_o     = wdata_q;
    assign tx_valid_o  = (state_q == RESP);
    assign tx_byte_o   = txb_q;
    assign core_hold_o = hold_q;
    assign busy_o      = (state_q != IDLE) && (state_q != RUN);
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a frame-level reference model
// queues expected writes/responses, a monitor pops them as the DUT emits.
module tb_uart_boot_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_dv_i;
    logic [7:0]  rx_byte_i;
    logic        we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o;
    logic        tx_valid_o;
    logic [7:0]  tx_byte_o;
    logic        tx_ready_i;
    logic        core_hold_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int rdy_mode = 1;

    logic [43:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  frm[$];
    logic        exp_err = 1'b0;
    logic        exp_hold = 1'b1;

    uart_boot_loader #(
        .AddrW(12),
        .TimeoutCycles(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_dv_i(rx_dv_i),
        .rx_byte_i(rx_byte_i),
        .we_o(we_o),
        .addr_o(addr_o),
        .wdata_o(wdata_o),
        .tx_valid_o(tx_valid_o),
        .tx_byte_o(tx_byte_o),
        .tx_ready_i(tx_ready_i),
        .core_hold_o(core_hold_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (rdy_mode == 0) tx_ready_i = 1'b0;
            else if (rdy_mode == 1) tx_ready_i = 1'b1;
            else tx_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every write strobe and every accepted response byte is
    // matched against the head of its expectation queue.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (we_o) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_we", {20'h0, addr_o}, 32'hFFFF_FFFF);
                    end else begin
                        logic [43:0] e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", {20'h0, addr_o}, {20'h0, e[43:32]});
                        chk("wr_data", wdata_o, e[31:0]);
                    end
                end
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_tx.size() == 0) begin
                        chk("unexpected_tx", {24'h0, tx_byte_o}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] t;
                        t = exp_tx.pop_front();
                        chk("tx_byte", {24'h0, tx_byte_o}, {24'h0, t});
                    end
                    resp_cnt++;
                end
            end
        end
    end

    // Reference model over a whole frame held in frm (frm[0] is SYNC).
    task automatic model_frame();
        logic [7:0]  s;
        logic        ok;
        logic [11:0] a;
        int          n;
        s = 8'h00;
        for (int i = 1; i < frm.size(); i++) s = s + frm[i];
        ok = (s == 8'h00);
        if (frm[1] == 8'h01) begin
            a = {frm[2][3:0], frm[3]};
            n = (frm[4] == 8'h00) ? 256 : int'(frm[4]);
            for (int w = 0; w < n; w++) begin
                int b;
                logic [11:0] wa;
                b  = 5 + 4 * w;
                wa = 12'((int'(a) + w) % 4096);
                exp_wr.push_back({wa, frm[b+3], frm[b+2], frm[b+1], frm[b]});
            end
        end else if (frm[1] != 8'h02) begin
            ok = 1'b0;
        end
        exp_tx.push_back(ok ? 8'h79 : 8'h1F);
        exp_err  = !ok;
        exp_hold = !(ok && frm[1] == 8'h02);
    endtask

    task automatic build_write(input logic [11:0] a, input logic [7:0] len,
                               input bit bad);
        logic [7:0] s;
        int n;
        frm = {};
        frm.push_back(8'hA5);
        frm.push_back(8'h01);
        frm.push_back({4'h0, a[11:8]});
        frm.push_back(a[7:0]);
        frm.push_back(len);
        n = (len == 8'h00) ? 256 : int'(len);
        for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
        s = 8'h00;
        for (int i = 1; i < frm.size(); i++) s = s + frm[i];
        frm.push_back(8'h00 - s + (bad ? 8'h01 : 8'h00));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv_i   = 1'b1;
        rx_byte_i = b;
        tick();
        rx_dv_i = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_resp(input int c0, input string name);
        int k;
        k = 0;
        while (resp_cnt == c0 && k < 3000) begin
            tick();
            k++;
        end
        chk({name, "_resp_seen"}, 32'(resp_cnt != c0), 32'd1);
    endtask

    task automatic run_frame(input int start, input string name);
        int c0;
        model_frame();
        c0 = resp_cnt;
        for (int i = start; i < frm.size(); i++) send_byte(frm[i]);
        wait_resp(c0, name);
        chk({name, "_err"}, 32'(err_o), 32'(exp_err));
        chk({name, "_hold"}, 32'(core_hold_o), 32'(exp_hold));
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_we"}, 32'(we_o), 32'd0);
        chk({name, "_addr"}, {20'h0, addr_o}, 32'd0);
        chk({name, "_wdata"}, wdata_o, 32'd0);
        chk({name, "_txv"}, 32'(tx_valid_o), 32'd0);
        chk({name, "_txb"}, {24'h0, tx_byte_o}, 32'd0);
        chk({name, "_hold"}, 32'(core_hold_o), 32'd1);
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
        chk({name, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        int c0;
        int k;
        reset     = 1'b1;
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        frm = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
        run_frame(0, "t1");
        chk("t1_addr_o", {20'h0, addr_o}, 32'h010);
        chk("t1_wdata_o", wdata_o, 32'h12345678);

        // BOOT with the tx side stalled; a stray byte in RESP is dropped.
        rdy_mode = 0;
        frm = '{8'hA5, 8'h02, 8'hFE};
        model_frame();
        c0 = resp_cnt;
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
        k = 0;
        while (!tx_valid_o && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_txv_stall", 32'(tx_valid_o), 32'd1);
            chk("t2_txb_stall", {24'h0, tx_byte_o}, 32'h79);
            rx_dv_i   = (i == 2);
            rx_byte_i = 8'hA5;
            tick();
        end
        rx_dv_i  = 1'b0;
        rdy_mode = 1;
        wait_resp(c0, "t2");
        chk("t2_hold", 32'(core_hold_o), 32'd0);
        chk("t2_busy", 32'(busy_o), 32'd0);

        // Sync in RUN re-asserts the hold, then a bad-checksum write.
        rx_dv_i   = 1'b1;
        rx_byte_i = 8'hA5;
        tick();
        rx_dv_i = 1'b0;
        chk("t6_hold_resync", 32'(core_hold_o), 32'd1);
        frm = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hDB};
        run_frame(1, "t3");
        frm = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
        run_frame(0, "t3_clear");

        build_write(12'hFFF, 8'h02, 1'b0);
        run_frame(0, "t4_wrap");
        frm = '{8'hA5, 8'h07};
        run_frame(0, "t4_badcmd");

        exp_tx.push_back(8'h1F);
        exp_err  = 1'b1;
        exp_hold = 1'b1;
        c0 = resp_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        wait_resp(c0, "t5_tmo");
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_busy", 32'(busy_o), 32'd0);

        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            int sel;
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g;
                g = 8'($urandom);
                send_byte(g == 8'hA5 ? 8'h00 : g);
            end
            sel = $urandom_range(0, 9);
            if (f == 4) begin
                build_write(12'($urandom), 8'h00, 1'b0);
            end else if (sel < 7) begin
                build_write(12'($urandom), 8'($urandom_range(1, 5)),
                            $urandom_range(0, 3) == 0);
            end else if (sel < 9) begin
                frm = '{8'hA5, 8'h02, 8'hFE};
                if ($urandom_range(0, 1) == 1) frm[2] = 8'hFD;
            end else begin
                frm = '{8'hA5, 8'h00};
                frm[1] = 8'($urandom_range(3, 255));
            end
            run_frame(0, "rand");
        end
        rdy_mode = 1;

        // Async reset with a partial word in flight.
        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_mid_busy_after", 32'(busy_o), 32'd0);
        chk("rst_mid_hold_after", 32'(core_hold_o), 32'd1);
        exp_err  = 1'b0;
        exp_hold = 1'b1;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
        run_frame(0, "post_rst");

        repeat (3) tick();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
